// File: rtl/seg7_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seg7_pkg : active-low segment/anode constants and digit index type.  Rev 1.0
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

  // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seg7_decode : 4-bit value to active-low seven-segment pattern (0-9, A-F). Rev 1.0
// -----------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (val_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      default: seg_o = SEG_F;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// -----------------------------------------------------------------------------
// seg7_scan_driver : 4-digit common-anode multiplexer with per-frame snapshot. Rev 1.0
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("seg7_scan_driver: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
    $error("seg7_scan_driver: BLANK_CYCLES must be < REFRESH_DIV");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           idx_q, idx_d;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic [3:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d, frame_start_d;
  logic [6:0]       dec_seg;
  logic [3:0]       lz_blank;

  seg7_decode u_decode (
    .val_i (snap_q[idx_q]),
    .seg_o (dec_seg)
  );

  // A digit is suppressed when it and every more-significant digit are zero.
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (LZ_BLANK != 0) && (snap_q[3] == 4'd0);
    lz_blank[2] = lz_blank[3] && (snap_q[2] == 4'd0);
    lz_blank[1] = lz_blank[2] && (snap_q[1] == 4'd0);
  end

  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    snap_d        = snap_q;
    snap_dp_d     = snap_dp_q;
    frame_start_d = 1'b0;
    an_d          = AN_OFF;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = digit_e'(idx_q + 2'd1);
      if (idx_q == DIG3) begin
        snap_d        = {thousands, hundreds, tens, ones};
        snap_dp_d     = dp_en;
        frame_start_d = 1'b1;
      end
    end

    if ((cnt_q >= BLANK_END) && !lz_blank[idx_q]) begin
      an_d  = an_sel(idx_q);
      seg_d = dec_seg;
      dp_d  = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      cnt_q       <= '0;
      idx_q       <= DIG0;
      snap_q      <= '0;
      snap_dp_q   <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      snap_dp_q   <= snap_dp_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver : directed + random bench against a frame-position model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic       reset;
  logic [3:0] ones, tens, hundreds, thousands, dp_en;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fs_a, fs_b;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1)) dut (
    .clk_100MHz (clk_100MHz), .reset (reset),
    .ones (ones), .tens (tens), .hundreds (hundreds), .thousands (thousands),
    .dp_en (dp_en), .an (an_a), .seg (seg_a), .dp (dp_a), .frame_start (fs_a)
  );

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(0)) dut_nolz (
    .clk_100MHz (clk_100MHz), .reset (reset),
    .ones (ones), .tens (tens), .hundreds (hundreds), .thousands (thousands),
    .dp_en (dp_en), .an (an_b), .seg (seg_b), .dp (dp_b), .frame_start (fs_b)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         pos;
  logic [3:0] msnap [4];
  logic [3:0] mdp;
  logic [6:0] font [16];

  // Expected {an, seg, dp, frame_start} after the next edge, from the frame position.
  function automatic logic [12:0] model_out(input bit lz);
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    int         slot, ph;
    bit         blank;
    a     = 4'hF;
    s     = 7'h7F;
    d     = 1'b1;
    slot  = pos / RD;
    ph    = pos % RD;
    blank = 1'b0;
    if (lz && slot > 0) begin
      blank = 1'b1;
      for (int i = slot; i < 4; i++)
        if (msnap[i] != 4'd0) blank = 1'b0;
    end
    if (ph >= BC && !blank) begin
      a[slot] = 1'b0;
      s       = font[msnap[slot]];
      d       = ~mdp[slot];
    end
    return {a, s, d, (pos == FRAME - 1)};
  endfunction

  task automatic tick();
    logic [12:0] ea, eb;
    bit          r;
    int          p0;
    r  = reset;
    p0 = pos;
    if (!r) begin
      ea = {4'hF, 7'h7F, 1'b1, 1'b0};
      eb = ea;
    end else begin
      ea = model_out(1'b1);
      eb = model_out(1'b0);
    end
    @(posedge clk_100MHz);
    #1;
    if (!r) begin
      pos = 0;
      for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
      mdp = 4'd0;
    end else begin
      if (pos == FRAME - 1) begin
        msnap[0] = ones;
        msnap[1] = tens;
        msnap[2] = hundreds;
        msnap[3] = thousands;
        mdp      = dp_en;
      end
      pos = (pos + 1) % FRAME;
    end
    vectors++;
    assert ({an_a, seg_a, dp_a, fs_a} === ea) else begin
      miscompares++;
      $error("FAIL lz1 pos=%0d rst=%0b observed an=%b seg=%b dp=%b fs=%b expected an=%b seg=%b dp=%b fs=%b",
             p0, r, an_a, seg_a, dp_a, fs_a, ea[12:9], ea[8:2], ea[1], ea[0]);
    end
    vectors++;
    assert ({an_b, seg_b, dp_b, fs_b} === eb) else begin
      miscompares++;
      $error("FAIL lz0 pos=%0d rst=%0b observed an=%b seg=%b dp=%b fs=%b expected an=%b seg=%b dp=%b fs=%b",
             p0, r, an_b, seg_b, dp_b, fs_b, eb[12:9], eb[8:2], eb[1], eb[0]);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int p);
    int guard;
    guard = 0;
    while (pos != p && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    vectors++;
    assert (pos == p) else begin
      miscompares++;
      $error("FAIL run_to observed pos=%0d expected pos=%0d", pos, p);
    end
  endtask

  task automatic set_digits(input logic [3:0] th, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] o,
                            input logic [3:0] dpv);
    thousands = th;
    hundreds  = h;
    tens      = t;
    ones      = o;
    dp_en     = dpv;
  endtask

  initial begin
    font[0]  = 7'b1000000; font[1]  = 7'b1111001; font[2]  = 7'b0100100; font[3]  = 7'b0110000;
    font[4]  = 7'b0011001; font[5]  = 7'b0010010; font[6]  = 7'b0000010; font[7]  = 7'b1111000;
    font[8]  = 7'b0000000; font[9]  = 7'b0010000; font[10] = 7'b0001000; font[11] = 7'b0000011;
    font[12] = 7'b1000110; font[13] = 7'b0100001; font[14] = 7'b0000110; font[15] = 7'b0001110;
    pos = 0;
    for (int i = 0; i < 4; i++) msnap[i] = 4'd0;
    mdp = 4'd0;

    // Reset held for three cycles, then the first frame shows snapshot 0.
    reset = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    run(3);
    reset = 1'b1;
    run(40);

    // All four digits with a decimal point on the tens digit.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0010);
    run(2 * FRAME);

    // Leading zeros suppressed on the LZ instance, shown on the other.
    set_digits(4'd0, 4'd0, 4'd0, 4'd7, 4'b1000);
    run(2 * FRAME);

    // Mid-frame change of ones must wait for the next snapshot.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'b0010);
    run(FRAME);
    run_to(2 * RD + 3);
    ones = 4'd9;
    run(2 * FRAME);

    // Hex glyphs.
    set_digits(4'd0, 4'd0, 4'hF, 4'hA, 4'b0000);
    run(2 * FRAME);

    // Reset at cnt=5 of slot 2 discards the snapshot and restarts at slot 0.
    run_to(2 * RD + 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run(FRAME + 8);

    // Random digit sets, biased toward zeros, with occasional resets.
    for (int k = 0; k < 40; k++) begin
      set_digits(($urandom % 2) ? 4'($urandom % 16) : 4'd0,
                 ($urandom % 2) ? 4'($urandom % 16) : 4'd0,
                 ($urandom % 2) ? 4'($urandom % 16) : 4'd0,
                 4'($urandom % 16), 4'($urandom % 16));
      if ($urandom % 8 == 0) begin
        reset = 1'b0;
        run(int'($urandom_range(1, 3)));
        reset = 1'b1;
      end
      run(int'($urandom_range(1, 48)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the four registered BCD digit nibbles (ones/tens/hundreds/thousands).
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display: anode select, segment decode, decimal points, leading-zero blanking, and an inter-digit blanking gap against ghosting.
- Takes a coherent snapshot of the digit inputs once per scan frame, so a display frame never mixes old and new values.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.
- BLANK_CYCLES, 1000, cycles at slot start with all anodes off; must be < REFRESH_DIV.
- LZ_BLANK, 1, 1 = suppress leading zeros on thousands, hundreds and tens; 0 = show all digits.

Ports:
- clk_100MHz  input  1  system clock; all logic is in this domain.
- reset  input  1  synchronous, active-low reset.
- ones  input  4  digit 0 value.
- tens  input  4  digit 1 value.
- hundreds  input  4  digit 2 value.
- thousands  input  4  digit 3 value.
- dp_en  input  4  decimal point enable per digit; bit i = digit i.
- an  output  4  anode enables, active-low; an[i] = digit i.
- seg  output  7  segments, active-low; seg[0]=a through seg[6]=g.
- dp  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse: a new snapshot is in use.

Behaviour:
- Reset: applied when reset==0 at a clk_100MHz edge. Clears cnt=0, idx=0, snapshot (digits and dp_en) = 0. Registered outputs: an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
- Slot counter: cnt runs 0..REFRESH_DIV-1 and wraps to 0. On wrap, idx advances 0->1->2->3->0.
- Snapshot: on the cycle where cnt==REFRESH_DIV-1 and idx==3, all digit inputs and dp_en are loaded into the snapshot. frame_start is registered high for exactly the next cycle, which is the first cycle of the digit-0 slot.
- The first frame after reset displays snapshot 0. With LZ_BLANK=1 this shows "0" on digit 0 only.
- Output timing: an, seg and dp are registered with 1-cycle latency from (idx, cnt).
- Blank phase (cnt < BLANK_CYCLES): an=4'b1111, seg=7'b1111111, dp=1.
- On phase (otherwise): an = ~(4'b0001 << idx), seg = decode(snap[idx]), dp = ~snap_dp[idx].
- Decode: 0-9 standard; 10-15 render as A,b,C,d,E,F. Active-low examples: 0=7'b1000000, 1=7'b1111001, 4=7'b0011001, 7=7'b1111000, A=7'b0001000.
- Leading-zero blanking (LZ_BLANK=1), evaluated on the snapshot:
  - thousands blanked if thousands==0.
  - hundreds blanked if thousands==0 and hundreds==0.
  - tens blanked if all three upper digits are 0.
  - ones is never blanked.
- A blanked digit behaves as blank phase for its whole slot; its dp_en bit is ignored.
- Input changes mid-frame do not affect the display until the next snapshot.
- Reset mid-slot: the next cycle shows the reset values, then scanning restarts at idx=0, cnt=0.
- Parameter violations (BLANK_CYCLES >= REFRESH_DIV, REFRESH_DIV < 2) cause an elaboration-time error.
- cnt width is $clog2(REFRESH_DIV); idx is 2 bits and wraps naturally.

Decomposition:
- Shared package seg7_pkg:
  - Active-low segment constants SEG_0..SEG_F and SEG_OFF=7'b1111111.
  - AN_OFF=4'b1111.
  - Function for the one-hot-low anode pattern.
- One sub-module: seg7_decode (combinational, 4-bit value -> 7-bit active-low segments), reusable elsewhere.
- Counter, snapshot, blanking logic and FSM stay in seg7_scan_driver.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1 unless stated):
- Reset: hold reset=0 for 3 cycles -> an=4'b1111, seg=7'b1111111, dp=1, frame_start=0. Release -> slots 1-3 blank; slot 0 on-phase shows an=4'b1110, seg=7'b1000000. frame_start pulses once 32 cycles after release.
- Digits th=1,h=2,t=3,o=4, dp_en=4'b0010:
  - Each slot: 2 blank cycles, then 6 on cycles.
  - Slot 0: an=1110, seg=0011001.
  - Slot 1: an=1101, seg=0110000, dp=0.
  - Slot 2: an=1011, seg=0100100.
  - Slot 3: an=0111, seg=1111001.
- Digits 0,0,0,7 with dp_en=4'b1000 -> only slot 0 drives an=1110, seg=1111000; slots 1-3 keep an=1111, dp=1. With LZ_BLANK=0, slots 1-3 show 7'b1000000 and slot 3 has dp=0.
- Change ones from 4 to 9 in the middle of slot 2 -> slot 0 keeps 7'b0011001 until after the next frame_start, then shows 7'b0010000.
- ones=4'hA, tens=4'hF, upper digits 0 -> slot 0 seg=7'b0001000, slot 1 seg=7'b0001110.
- Assert reset at cnt=5 of slot 2 -> outputs off the next cycle; after release, scanning restarts at slot 0, cnt=0, and the snapshot is 0.
